// File: rtl/async_filter_pkg.sv
// Shared edge classification for the asynchronous input filter.
package async_filter_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_e;

  // Classify a change of the debounced level.
  function automatic edge_e edge_of(input logic old_v, input logic new_v);
    edge_e e;
    e = EDGE_NONE;
    if (!old_v && new_v) e = EDGE_RISE;
    if (old_v && !new_v) e = EDGE_FALL;
    return e;
  endfunction

endpackage

// File: rtl/async_filter_ch.sv
// One channel: plain DFF synchronizer, hold-count debouncer, edge pulses.
module async_filter_ch
  import async_filter_pkg::*;
#(
  parameter int unsigned N_DFF = 3,
  parameter int unsigned HOLD  = 4,
  parameter logic        INIT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall,
  output logic o_pulse_nxt_c
);

  localparam int unsigned CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

  logic [N_DFF-1:0] r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_rise;
  logic             r_fall;

  logic             w_sync;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_stable_nxt;
  logic             w_flip;
  edge_e            w_edge;

  assign w_sync = r_sync[N_DFF-1];

  // Synchronizer chain: pure shift, nothing between stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= {N_DFF{INIT}};
    end else begin
      r_sync <= {r_sync[N_DFF-2:0], i_async};
    end
  end

  // Debounce decision: any agreeing cycle restarts the run of disagreements.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_stable_nxt = r_stable;
    w_flip       = 1'b0;
    w_edge       = EDGE_NONE;
    if (w_sync == r_stable) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_stable_nxt = w_sync;
      w_cnt_nxt    = '0;
      w_flip       = 1'b1;
      w_edge       = edge_of(r_stable, w_sync);
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Debounced state, counter and registered edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= INIT;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_stable <= w_stable_nxt;
      r_rise   <= (w_edge == EDGE_RISE);
      r_fall   <= (w_edge == EDGE_FALL);
    end
  end

  assign o_sync        = w_sync;
  assign o_stable      = r_stable;
  assign o_rise        = r_rise;
  assign o_fall        = r_fall;
  assign o_pulse_nxt_c = w_flip;

endmodule

// File: rtl/async_filter.sv
// Multi-channel synchronizer/debouncer with per-channel edge pulses.
module async_filter
  import async_filter_pkg::*;
#(
  parameter int unsigned     N_CH  = 1,
  parameter int unsigned     N_DFF = 3,
  parameter int unsigned     HOLD  = 4,
  parameter logic [N_CH-1:0] INIT  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] async_in,
  output logic [N_CH-1:0] sync_out,
  output logic [N_CH-1:0] stable,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_edge
);

  logic [N_CH-1:0] w_pulse_nxt;
  logic            r_any_edge;

  // Independent channels; only the edge summary is shared.
  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    async_filter_ch #(
      .N_DFF (N_DFF),
      .HOLD  (HOLD),
      .INIT  (INIT[g])
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_async       (async_in[g]),
      .o_sync        (sync_out[g]),
      .o_stable      (stable[g]),
      .o_rise        (rise[g]),
      .o_fall        (fall[g]),
      .o_pulse_nxt_c (w_pulse_nxt[g])
    );
  end

  // Edge summary registered alongside the per-channel pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_any_edge <= 1'b0;
    end else begin
      r_any_edge <= |w_pulse_nxt;
    end
  end

  assign any_edge = r_any_edge;

endmodule

// File: tb/tb_async_filter.sv
// Bench for async_filter: two instances (INIT=0 and INIT=F) on shared stimulus.
module tb_async_filter;

  localparam int N_DFF = 3;
  localparam int HOLD  = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] async_in;

  logic [3:0] s0, st0, r0, f0;
  logic       a0;
  logic [3:0] s1, st1, r1, f1;
  logic       a1;

  int checks = 0;
  int errors = 0;

  async_filter #(.N_CH(4), .N_DFF(N_DFF), .HOLD(HOLD), .INIT(4'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in),
    .sync_out(s0), .stable(st0), .rise(r0), .fall(f0), .any_edge(a0)
  );

  async_filter #(.N_CH(4), .N_DFF(N_DFF), .HOLD(HOLD), .INIT(4'hF)) dut1 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in),
    .sync_out(s1), .stable(st1), .rise(r1), .fall(f1), .any_edge(a1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: input log plus "last HOLD samples all disagree" rule.
  logic [3:0] in_log [0:8191];
  int         ecnt = 0;
  int         last_rst = 0;
  int         last_flip [2][4];
  logic [3:0] m_sync [2];
  logic [3:0] m_stab [2];
  logic [3:0] m_rise [2];
  logic [3:0] m_fall [2];
  logic       m_any  [2];

  function automatic logic [3:0] init_of(input int d);
    return (d == 0) ? 4'h0 : 4'hF;
  endfunction

  // Synchronized value visible after edge k: raw input from N_DFF-1 edges earlier.
  function automatic logic [3:0] sync_at(input int d, input int k);
    if (k - (N_DFF - 1) <= last_rst) return init_of(d);
    return in_log[k - (N_DFF - 1)];
  endfunction

  always @(posedge clk) begin
    ecnt = ecnt + 1;
    if (!rst_n) begin
      last_rst = ecnt;
      for (int d = 0; d < 2; d++) begin
        m_sync[d] = init_of(d);
        m_stab[d] = init_of(d);
        m_rise[d] = 4'h0;
        m_fall[d] = 4'h0;
        m_any[d]  = 1'b0;
        for (int c = 0; c < 4; c++) last_flip[d][c] = ecnt;
      end
    end else begin
      in_log[ecnt] = async_in;
      for (int d = 0; d < 2; d++) begin
        m_rise[d] = 4'h0;
        m_fall[d] = 4'h0;
        for (int c = 0; c < 4; c++) begin
          bit ok;
          logic [3:0] smp;
          ok = (ecnt - HOLD >= last_flip[d][c]);
          for (int k = ecnt - HOLD; k < ecnt; k++) begin
            if (ok) begin
              smp = sync_at(d, k);
              if (smp[c] == m_stab[d][c]) ok = 1'b0;
            end
          end
          if (ok) begin
            m_stab[d][c] = ~m_stab[d][c];
            if (m_stab[d][c]) m_rise[d][c] = 1'b1;
            else              m_fall[d][c] = 1'b1;
            last_flip[d][c] = ecnt;
          end
        end
        m_any[d]  = |{m_rise[d], m_fall[d]};
        m_sync[d] = sync_at(d, ecnt);
      end
    end
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d0.sync",   s0,          m_sync[0]);
    chk("d0.stable", st0,         m_stab[0]);
    chk("d0.rise",   r0,          m_rise[0]);
    chk("d0.fall",   f0,          m_fall[0]);
    chk("d0.any",    {3'b0, a0},  {3'b0, m_any[0]});
    chk("d1.sync",   s1,          m_sync[1]);
    chk("d1.stable", st1,         m_stab[1]);
    chk("d1.rise",   r1,          m_rise[1]);
    chk("d1.fall",   f1,          m_fall[1]);
    chk("d1.any",    {3'b0, a1},  {3'b0, m_any[1]});
  endtask

  // One clock, then compare everything away from the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  int cnt_a, cnt_b;

  initial begin
    rst_n    = 1'b0;
    async_in = 4'hF;

    // Reset with inputs high: everything held at INIT, no pulses.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.d0.sync",   s0,  4'h0);
      chk("rst.d0.stable", st0, 4'h0);
      chk("rst.d0.edges",  {r0 | f0}, 4'h0);
      chk("rst.d0.any",    {3'b0, a0}, 4'h0);
      chk("rst.d1.stable", st1, 4'hF);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst.d0.sync",   s0,  4'h0);
    chk("post_rst.d0.stable", st0, 4'h0);
    chk("post_rst.d0.edges",  {r0 | f0}, 4'h0);
    chk("post_rst.d0.any",    {3'b0, a0}, 4'h0);
    chk("post_rst.d1.edges",  {r1 | f1}, 4'h0);
    async_in = 4'h0;
    repeat (12) tick();

    // Step on channel 0.
    async_in = 4'h1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) chk("step.sync_early", {3'b0, s0[0]}, 4'h0);
      if (i == 3) chk("step.sync",       {3'b0, s0[0]}, 4'h1);
      if (i == 6) chk("step.stable_early", {3'b0, st0[0]}, 4'h0);
      if (i == 7) begin
        chk("step.stable", {3'b0, st0[0]}, 4'h1);
        chk("step.rise",   r0, 4'h1);
        chk("step.any",    {3'b0, a0}, 4'h1);
      end
      if (i == 8) chk("step.rise_single", r0, 4'h0);
    end

    // Three-cycle glitch on channel 1 is rejected.
    cnt_a = 0;
    cnt_b = 0;
    async_in = 4'h3;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 3) async_in = 4'h1;
      if (s0[1]) cnt_a++;
      if (r0[1]) cnt_b++;
    end
    chk("glitch.sync_cycles", 4'(cnt_a), 4'd3);
    chk("glitch.rise",        4'(cnt_b), 4'd0);
    chk("glitch.stable",      {3'b0, st0[1]}, 4'h0);

    // Chatter on channel 2, then a steady high.
    cnt_b = 0;
    for (int p = 0; p < 10; p++) begin
      async_in[2] = ((p % 2) == 0);
      repeat (2) begin
        tick();
        if (r0[2]) cnt_b++;
      end
    end
    async_in[2] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (r0[2]) cnt_b++;
      if (i == 6) chk("chatter.stable_early", {3'b0, st0[2]}, 4'h0);
      if (i == 7) chk("chatter.stable",       {3'b0, st0[2]}, 4'h1);
    end
    chk("chatter.rise_count", 4'(cnt_b), 4'd1);

    // Two channels changing together.
    async_in = 4'h8;
    repeat (12) tick();
    chk("simul.pre_stable", st0, 4'h8);
    cnt_a = 0;
    async_in = 4'h4;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (a0) cnt_a++;
      if (i == 7) begin
        chk("simul.rise", r0, 4'h4);
        chk("simul.fall", f0, 4'h8);
        chk("simul.any",  {3'b0, a0}, 4'h1);
      end
    end
    chk("simul.any_count", 4'(cnt_a), 4'd1);

    // Reset while counts are at 2; both INIT values.
    async_in = 4'hB;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst.d0.stable", st0, 4'h0);
    chk("midrst.d0.edges",  {r0 | f0}, 4'h0);
    chk("midrst.d1.stable", st1, 4'hF);
    chk("midrst.d1.edges",  {r1 | f1}, 4'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        chk("midrst.rel.d0.any", {3'b0, a0}, 4'h0);
        chk("midrst.rel.d1.any", {3'b0, a1}, 4'h0);
      end
      if (i == 6) begin
        chk("midrst.d0.hold", st0, 4'h0);
        chk("midrst.d1.hold", st1, 4'hF);
      end
      if (i == 7) begin
        chk("midrst.d0.stable_new", st0, 4'hB);
        chk("midrst.d0.rise",       r0,  4'hB);
        chk("midrst.d1.stable_new", st1, 4'hB);
        chk("midrst.d1.fall",       f1,  4'h4);
      end
    end

    // Random levels with occasional resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7, 0) == 0) async_in = 4'($urandom);
      rst_n = ($urandom_range(63, 0) != 0);
      tick();
    end
    rst_n = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_filter.md
ASYNC_FILTER -- requirements
Module: async_filter

Interface
REQ-001 SHALL have parameter N_CH, default 1: number of independent asynchronous input channels, 1..32.
REQ-002 SHALL have parameter N_DFF, default 3: synchronizer stages per channel, minimum 2.
REQ-003 SHALL have parameter HOLD, default 4: consecutive synchronized cycles required before the debounced state changes, minimum 1.
REQ-004 SHALL have parameter INIT, default 0: N_CH-bit reset value of all synchronizer stages and debounced state.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port async_in, input, N_CH: asynchronous raw inputs.
REQ-008 SHALL have port sync_out, output, N_CH: synchronized, undebounced inputs (final DFF stage).
REQ-009 SHALL have port stable, output, N_CH: debounced state per channel.
REQ-010 SHALL have port rise, output, N_CH: one-cycle pulse on a 0->1 change of stable.
REQ-011 SHALL have port fall, output, N_CH: one-cycle pulse on a 1->0 change of stable.
REQ-012 SHALL have port any_edge, output, 1: OR of all rise and fall bits, registered with them.

Function
REQ-013 SHALL shift each async_in bit through an N_DFF-deep chain; sync_out SHALL reflect an input level exactly N_DFF rising edges after it is first sampled.
REQ-014 SHALL keep one counter per channel, width clog2(HOLD+1), saturating never reached (cleared before overflow).
REQ-015 Each cycle, per channel: sync_out == stable -> count <= 0; sync_out != stable and count < HOLD-1 -> count <= count+1; sync_out != stable and count == HOLD-1 -> stable <= sync_out, count <= 0.
REQ-016 Consequently stable SHALL change only after sync_out differs from it for HOLD consecutive cycles; total latency async_in -> stable = N_DFF+HOLD cycles.
REQ-017 With HOLD=1, stable SHALL follow sync_out with one cycle of delay and no filtering.
REQ-018 Any cycle with sync_out == stable SHALL restart the count from 0 (glitch rejection; no partial credit).
REQ-019 rise/fall SHALL be registered and asserted in the same cycle stable first shows its new value, for exactly one cycle.
REQ-020 rise and fall of one channel SHALL never be asserted together; different channels are independent and may pulse in the same cycle.
REQ-021 any_edge SHALL assert in the same cycle as any rise or fall bit.
REQ-022 Channels SHALL share no state other than any_edge.

Reset
REQ-023 While rst_n is low at a clk edge: all DFF stages and stable <= INIT, counters <= 0, rise/fall/any_edge <= 0.
REQ-024 Reset asserted mid-count SHALL discard the count; no rise/fall pulse SHALL be produced by reset or in the first cycle after it.
REQ-025 Outputs SHALL be undefined before the first clk edge with rst_n low; no asynchronous reset path SHALL exist.

Structure
REQ-026 No shared package types are required; counter width SHALL be a localparam computed inside the block.
REQ-027 Per-channel logic SHALL be a sub-module async_filter_ch (one DFF chain, counter, stable bit, edge pulses), instantiated N_CH times via generate; any_edge OR-reduction stays in the top.
REQ-028 DFF chain registers SHALL carry no logic between stages.

Verification (N_CH=4, N_DFF=3, HOLD=4, INIT=4'h0 unless stated)
REQ-029 Reset: rst_n=0 two cycles with async_in=4'hF -> sync_out, stable, rise, fall = 0, any_edge=0 during reset and the cycle after release.
REQ-030 Step: async_in[0] 0->1 held -> sync_out[0]=1 after 3 cycles, stable[0]=1 and rise[0]=1 (single cycle) after 7 cycles, any_edge=1 same cycle.
REQ-031 Glitch: async_in[1] high for 3 cycles -> sync_out[1] high 3 cycles, stable[1] stays 0, no rise[1].
REQ-032 Chatter: async_in[2] toggles every 2 cycles for 20 cycles then holds 1 -> stable[2] rises once, 7 cycles after final hold, exactly one rise[2].
REQ-033 Simultaneous: stable=4'h8, async_in 4'h8->4'h4 same cycle -> rise[2] and fall[3] both pulse in one cycle, any_edge one pulse.
REQ-034 Reset mid-count: rst_n low when count=2 -> stable=INIT, no pulses, full HOLD restart after release; repeat with INIT=4'hF.
